addsub_seq: RTL



---
 rtl/alu_pkg.sv | 14 +
 rtl/addsub_chk.sv | 14 +
 rtl/addsub_chunk.sv | 20 ++
 rtl/addsub_seq.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared execute-stage ALU definitions: operation codes and the add/subtract
// sequencer state encoding.
package alu_pkg;

   localparam logic ALU_ADD = 1'b0;
   localparam logic ALU_SUB = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } alu_state_e;

endpackage

// File: rtl/addsub_chk.sv
// Checker: the sign-based overflow and the carry-based overflow
// (msb_cin ^ cout) must agree on every final chunk.
module addsub_chk (
   input logic clk,
   input logic rst,
   input logic en,
   input logic ovf_sign,
   input logic ovf_carry
);

   a_ovf_agree: assert property (@(posedge clk) disable iff (rst)
      en |-> (ovf_sign == ovf_carry));

endmodule

// File: rtl/addsub_chunk.sv
// Combinational CHUNK-bit adder slice with carry in/out and the carry into
// its most significant bit.
module addsub_chunk #(
   parameter int CHUNK = 16
) (
   input  logic [CHUNK-1:0] x,
   input  logic [CHUNK-1:0] y,
   input  logic             cin,
   output logic [CHUNK-1:0] s,
   output logic             cout,
   output logic             msb_cin
);

   // Slice sum; the MSB carry-in is recovered from the MSB sum bit.
   always_comb begin
      {cout, s} = {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, cin};
      msb_cin   = x[CHUNK-1] ^ y[CHUNK-1] ^ s[CHUNK-1];
   end

endmodule

// File: rtl/addsub_seq.sv
// Multi-cycle signed add/subtract unit: CHUNK bits per cycle through a
// registered carry, valid/ready on both sides, Y86 condition-code flags.
module addsub_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = 64,
   parameter int CHUNK = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out,
   output logic             overflow,
   output logic             carry,
   output logic             zero,
   output logic             sign
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

   alu_state_e       state_r;
   alu_state_e       state_nxt_s;
   logic [WIDTH-1:0] a_r;
   logic [WIDTH-1:0] b_r;
   logic [WIDTH-1:0] res_r;
   logic [WIDTH-1:0] res_nxt_s;
   logic [WIDTH-1:0] out_r;
   logic [IDXW-1:0]  idx_r;
   logic             c_r;
   logic             ovf_r;
   logic             carry_r;
   logic             zero_r;
   logic             sign_r;
   logic             out_valid_r;
   logic [CHUNK-1:0] x_s;
   logic [CHUNK-1:0] y_s;
   logic [CHUNK-1:0] sum_s;
   logic             cout_s;
   logic             msb_cin_s;
   logic             accept_s;
   logic             last_s;
   logic             ovf_s;

   assign in_ready = (state_r == ST_IDLE) && !rst;
   assign accept_s = in_valid && in_ready;
   assign last_s   = (state_r == ST_RUN) && (idx_r == LAST_IDX);

   assign x_s = a_r[int'(idx_r) * CHUNK +: CHUNK];
   assign y_s = b_r[int'(idx_r) * CHUNK +: CHUNK];

   addsub_chunk #(.CHUNK(CHUNK)) u_chunk (
      .x       (x_s),
      .y       (y_s),
      .cin     (c_r),
      .s       (sum_s),
      .cout    (cout_s),
      .msb_cin (msb_cin_s)
   );

   // b_r already holds the inverted subtrahend, so this covers add and subtract.
   assign ovf_s = (a_r[WIDTH-1] == b_r[WIDTH-1]) && (sum_s[CHUNK-1] != a_r[WIDTH-1]);

   addsub_chk u_chk (
      .clk       (clk),
      .rst       (rst),
      .en        (last_s),
      .ovf_sign  (ovf_s),
      .ovf_carry (msb_cin_s ^ cout_s)
   );

   // Result with the current chunk merged in; the full value on the last chunk.
   always_comb begin
      res_nxt_s = res_r;
      res_nxt_s[int'(idx_r) * CHUNK +: CHUNK] = sum_s;
   end

   // Next-state logic.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: if (accept_s) state_nxt_s = ST_RUN;
                  else          state_nxt_s = ST_IDLE;
         ST_RUN:  if (idx_r == LAST_IDX) state_nxt_s = ST_DONE;
                  else                   state_nxt_s = ST_RUN;
         ST_DONE: if (out_ready) state_nxt_s = ST_IDLE;
                  else           state_nxt_s = ST_DONE;
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_r <= ST_IDLE;
      else     state_r <= state_nxt_s;
   end

   // Operand capture, chunk iteration and result/flag registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_r         <= {WIDTH{1'b0}};
         b_r         <= {WIDTH{1'b0}};
         res_r       <= {WIDTH{1'b0}};
         out_r       <= {WIDTH{1'b0}};
         idx_r       <= {IDXW{1'b0}};
         c_r         <= 1'b0;
         ovf_r       <= 1'b0;
         carry_r     <= 1'b0;
         zero_r      <= 1'b0;
         sign_r      <= 1'b0;
         out_valid_r <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (accept_s) begin
                  a_r   <= a;
                  b_r   <= (op == ALU_SUB) ? ~b : b;
                  c_r   <= (op == ALU_SUB);
                  idx_r <= {IDXW{1'b0}};
               end
            end
            ST_RUN: begin
               res_r <= res_nxt_s;
               c_r   <= cout_s;
               idx_r <= idx_r + IDXW'(1);
               if (last_s) begin
                  out_r       <= res_nxt_s;
                  carry_r     <= cout_s;
                  ovf_r       <= ovf_s;
                  zero_r      <= (res_nxt_s == {WIDTH{1'b0}});
                  sign_r      <= res_nxt_s[WIDTH-1];
                  out_valid_r <= 1'b1;
               end
            end
            ST_DONE: begin
               if (out_ready) out_valid_r <= 1'b0;
            end
            default: begin
               out_valid_r <= 1'b0;
            end
         endcase
      end
   end

   assign out       = out_r;
   assign overflow  = ovf_r;
   assign carry     = carry_r;
   assign zero      = zero_r;
   assign sign      = sign_r;
   assign out_valid = out_valid_r;

endmodule
